grf_wb_queue: RTL and testbench

GRF_WB_QUEUE -- requirements
Module: grf_wb_queue

---
 rtl/grf_wb_queue_pkg.sv | 20 ++
 rtl/grf_wb_match.sv | 42 ++++
 rtl/grf_wb_queue.sv | 140 ++++++++++++++
 tb/tb_grf_wb_queue.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/grf_wb_queue_pkg.sv
// ============================================================================
// Module : grf_wb_queue_pkg
// Brief  : Shared types and constants for the GRF write-back queue.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package grf_wb_queue_pkg;

    localparam int c_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc;
    } grf_wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/grf_wb_match.sv
// ============================================================================
// Module : grf_wb_match
// Brief  : Combinational youngest-match search over the write-back FIFO.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module grf_wb_match
    import grf_wb_queue_pkg::*;
#(
    parameter int DEPTH = c_DEPTH_DEFAULT,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic [DEPTH-1:0][4:0]  a3s,
    input  logic [DEPTH-1:0][31:0] wds,
    input  logic [PW-1:0]          head,
    input  logic [CW-1:0]          count,
    input  logic [4:0]             addr,
    output logic                   hit,
    output logic [31:0]            fwd
);

    logic [PW-1:0] w_idx;

    // Walk oldest to youngest so the last match found wins.
    always_comb begin
        hit   = 1'b0;
        fwd   = '0;
        w_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = head + PW'(i);
            if ((CW'(i) < count) && (addr != 5'd0) && (a3s[w_idx] == addr)) begin
                hit = 1'b1;
                fwd = wds[w_idx];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/grf_wb_queue.sv
// ============================================================================
// Module : grf_wb_queue
// Brief  : Two-source in-order write-back FIFO feeding the GRF write port.
//          Optional decode bypass lookup enabled by macro GRF_WB_FWD_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module grf_wb_queue
    import grf_wb_queue_pkg::*;
#(
    parameter int DEPTH = c_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     s0_valid,
    output logic                     s0_ready,
    input  logic [4:0]               s0_a3,
    input  logic [31:0]              s0_wd,
    input  logic [31:0]              s0_pc,
    input  logic                     s1_valid,
    output logic                     s1_ready,
    input  logic [4:0]               s1_a3,
    input  logic [31:0]              s1_wd,
    input  logic [31:0]              s1_pc,
    output logic                     we,
    output logic [4:0]               a3,
    output logic [31:0]              wd,
    output logic [31:0]              pc,
    output logic [$clog2(DEPTH):0]   count
`ifdef GRF_WB_FWD_EN
    ,
    input  logic [4:0]               a1,
    input  logic [4:0]               a2,
    output logic                     hit1,
    output logic [31:0]              fwd1,
    output logic                     hit2,
    output logic [31:0]              fwd2
`endif
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = c_PW + 1;

    grf_wb_entry_t   r_mem [DEPTH];
    logic [c_PW-1:0] r_head;
    logic [c_PW-1:0] r_tail;
    logic [c_CW-1:0] r_count;

    logic            w_nonempty;
    logic            w_pop;
    logic            w_s0_nz;
    logic            w_push0;
    logic            w_push1;
    logic [c_CW-1:0] w_free;
    logic [c_PW-1:0] w_tail1;
    grf_wb_entry_t   w_head_ent;

    assign w_nonempty = (r_count != '0);
    assign w_pop      = w_nonempty && !clr;
    assign w_free     = c_CW'(DEPTH) - r_count + c_CW'(w_nonempty);
    assign w_s0_nz    = s0_valid && (s0_a3 != 5'd0);

    // s1 must leave a slot for a non-discarded s0 offer.
    assign s0_ready   = (w_free >= c_CW'(1)) && !clr;
    assign s1_ready   = (w_free >= (c_CW'(1) + c_CW'(w_s0_nz))) && !clr;

    assign w_push0    = s0_ready && w_s0_nz;
    assign w_push1    = s1_ready && s1_valid && (s1_a3 != 5'd0);
    assign w_tail1    = w_push0 ? (r_tail + c_PW'(1)) : r_tail;

    assign w_head_ent = r_mem[r_head];
    assign we         = w_pop;
    assign a3         = w_nonempty ? w_head_ent.a3 : 5'd0;
    assign wd         = w_nonempty ? w_head_ent.wd : 32'd0;
    assign pc         = w_nonempty ? w_head_ent.pc : 32'd0;
    assign count      = r_count;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push0) begin
                r_mem[r_tail] <= '{a3: s0_a3, wd: s0_wd, pc: s0_pc};
            end
            if (w_push1) begin
                r_mem[w_tail1] <= '{a3: s1_a3, wd: s1_wd, pc: s1_pc};
            end
            r_head  <= r_head + c_PW'(w_pop);
            r_tail  <= r_tail + c_PW'(w_push0) + c_PW'(w_push1);
            r_count <= r_count + c_CW'(w_push0) + c_CW'(w_push1) - c_CW'(w_pop);
        end
    end

`ifdef GRF_WB_FWD_EN
    logic [DEPTH-1:0][4:0]  w_a3s;
    logic [DEPTH-1:0][31:0] w_wds;
    logic                   w_hit1;
    logic                   w_hit2;
    logic [31:0]            w_fwd1;
    logic [31:0]            w_fwd2;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_a3s[i] = r_mem[i].a3;
            w_wds[i] = r_mem[i].wd;
        end
    end

    grf_wb_match #(.DEPTH(DEPTH)) u_match1 (
        .a3s   (w_a3s),
        .wds   (w_wds),
        .head  (r_head),
        .count (r_count),
        .addr  (a1),
        .hit   (w_hit1),
        .fwd   (w_fwd1)
    );

    grf_wb_match #(.DEPTH(DEPTH)) u_match2 (
        .a3s   (w_a3s),
        .wds   (w_wds),
        .head  (r_head),
        .count (r_count),
        .addr  (a2),
        .hit   (w_hit2),
        .fwd   (w_fwd2)
    );

    assign hit1 = w_hit1 && !clr;
    assign fwd1 = clr ? 32'd0 : w_fwd1;
    assign hit2 = w_hit2 && !clr;
    assign fwd2 = clr ? 32'd0 : w_fwd2;
`endif

endmodule

`default_nettype wire

// File: tb/tb_grf_wb_queue.sv
// ============================================================================
// Module : tb_grf_wb_queue
// Brief  : Scoreboard bench for grf_wb_queue (directed + random traffic).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_grf_wb_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct {
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc;
    } ent_t;

    logic          clk = 1'b0;
    logic          clr;
    logic          s0_valid, s1_valid;
    logic          s0_ready, s1_ready;
    logic [4:0]    s0_a3, s1_a3;
    logic [31:0]   s0_wd, s0_pc, s1_wd, s1_pc;
    logic          we;
    logic [4:0]    a3;
    logic [31:0]   wd, pc;
    logic [CW-1:0] count;
`ifdef GRF_WB_FWD_EN
    logic [4:0]    a1, a2;
    logic          hit1, hit2;
    logic [31:0]   fwd1, fwd2;
`endif

    ent_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    grf_wb_queue #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .clr      (clr),
        .s0_valid (s0_valid),
        .s0_ready (s0_ready),
        .s0_a3    (s0_a3),
        .s0_wd    (s0_wd),
        .s0_pc    (s0_pc),
        .s1_valid (s1_valid),
        .s1_ready (s1_ready),
        .s1_a3    (s1_a3),
        .s1_wd    (s1_wd),
        .s1_pc    (s1_pc),
        .we       (we),
        .a3       (a3),
        .wd       (wd),
        .pc       (pc),
        .count    (count)
`ifdef GRF_WB_FWD_EN
        ,
        .a1       (a1),
        .a2       (a2),
        .hit1     (hit1),
        .fwd1     (fwd1),
        .hit2     (hit2),
        .fwd2     (fwd2)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Youngest stored entry whose destination matches; register 0 never hits.
    function automatic void exp_byp(input logic [4:0] a, output logic h, output logic [31:0] f);
        h = 1'b0;
        f = 32'd0;
        if (a != 5'd0) begin
            for (int i = sb_q.size() - 1; i >= 0; i--) begin
                if (sb_q[i].a3 == a) begin
                    h = 1'b1;
                    f = sb_q[i].wd;
                    break;
                end
            end
        end
    endfunction

    // One cycle of stimulus: drive, check readies/count against the model, record accepts.
    task automatic cyc(input logic c,
                       input logic v0, input logic [4:0] x0, input logic [31:0] d0, input logic [31:0] p0,
                       input logic v1, input logic [4:0] x1, input logic [31:0] d1, input logic [31:0] p1,
                       input logic [4:0] r1, input logic [4:0] r2);
        int   n;
        int   free;
        logic e0r, e1r;
        logic eh;
        logic [31:0] ef;
        @(negedge clk);
        clr = c;
        s0_valid = v0; s0_a3 = x0; s0_wd = d0; s0_pc = p0;
        s1_valid = v1; s1_a3 = x1; s1_wd = d1; s1_pc = p1;
`ifdef GRF_WB_FWD_EN
        a1 = r1;
        a2 = r2;
`endif
        #1;
        n    = sb_q.size();
        free = DEPTH - n + ((n != 0) ? 1 : 0);
        e0r  = !c && (free >= 1);
        e1r  = !c && (free >= 1 + ((v0 && x0 != 5'd0) ? 1 : 0));
        chk("count", 32'(count), 32'(n));
        chk("we", 32'(we), 32'(n != 0 && !c));
        chk("s0_ready", 32'(s0_ready), 32'(e0r));
        chk("s1_ready", 32'(s1_ready), 32'(e1r));
        if (n == 0) begin
            chk("idle_a3", 32'(a3), 32'd0);
            chk("idle_wd", wd, 32'd0);
            chk("idle_pc", pc, 32'd0);
        end
`ifdef GRF_WB_FWD_EN
        exp_byp(r1, eh, ef);
        if (c) begin eh = 1'b0; ef = 32'd0; end
        chk("hit1", 32'(hit1), 32'(eh));
        chk("fwd1", fwd1, ef);
        exp_byp(r2, eh, ef);
        if (c) begin eh = 1'b0; ef = 32'd0; end
        chk("hit2", 32'(hit2), 32'(eh));
        chk("fwd2", fwd2, ef);
`else
        eh = (r1 == r2);
        ef = 32'(eh);
`endif
        if (c) begin
            sb_q.delete();
        end else begin
            if (v0 && e0r && x0 != 5'd0) sb_q.push_back('{a3: x0, wd: d0, pc: p0});
            if (v1 && e1r && x1 != 5'd0) sb_q.push_back('{a3: x1, wd: d1, pc: p1});
        end
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
    endtask

    // Monitor: every GRF write must be the oldest expected entry.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (we === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_write actual=a3 %0d wd 0x%0h required=no write", a3, wd);
                end else begin
                    ent_t e;
                    e = sb_q.pop_front();
                    chk("wr_a3", 32'(a3), 32'(e.a3));
                    chk("wr_wd", wd, e.wd);
                    chk("wr_pc", pc, e.pc);
                end
            end
        end
    end

    function automatic logic [4:0] rnd_a3();
        return ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
    endfunction

    function automatic logic [4:0] rnd_ra();
        if (sb_q.size() > 0 && $urandom_range(1) == 1)
            return sb_q[$urandom_range(sb_q.size() - 1)].a3;
        return 5'($urandom_range(31));
    endfunction

    initial begin
        clr = 1'b1;
        s0_valid = 1'b0; s0_a3 = '0; s0_wd = '0; s0_pc = '0;
        s1_valid = 1'b0; s1_a3 = '0; s1_wd = '0; s1_pc = '0;
`ifdef GRF_WB_FWD_EN
        a1 = '0;
        a2 = '0;
`endif
        cyc(1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        cyc(1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        idle(1);

        // Single write
        cyc(1'b0, 1'b1, 5'd5, 32'h1234, 32'h3000, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        idle(2);

        // Zero-register discard alongside a real s1 write
        cyc(1'b0, 1'b1, 5'd0, 32'hDEAD, 32'h100, 1'b1, 5'd7, 32'h77, 32'h104, 5'd0, 5'd0);
        idle(2);

        // Two writes to the same register, bypass must return the younger
        cyc(1'b0, 1'b1, 5'd9, 32'hA, 32'h200, 1'b1, 5'd9, 32'hB, 32'h204, 5'd0, 5'd0);
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd9, 5'd0);
        idle(2);

        // Fill from both sources every cycle
        for (int i = 0; i < 8; i++)
            cyc(1'b0, 1'b1, 5'(2 * i + 1), 32'(16'h100 + i), 32'(16'h4000 + 8 * i),
                      1'b1, 5'(2 * i + 2), 32'(16'h200 + i), 32'(16'h4004 + 8 * i), 5'(2 * i), 5'd3);
        idle(DEPTH + 1);

        // Reset mid-operation with an offered entry
        cyc(1'b0, 1'b1, 5'd1, 32'h11, 32'h500, 1'b1, 5'd2, 32'h22, 32'h504, 5'd0, 5'd0);
        cyc(1'b0, 1'b1, 5'd3, 32'h33, 32'h508, 1'b1, 5'd4, 32'h44, 32'h50C, 5'd3, 5'd0);
        cyc(1'b1, 1'b1, 5'd5, 32'h55, 32'h510, 1'b0, 5'd0, 32'd0, 32'd0, 5'd3, 5'd4);
        idle(2);

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(49) == 0),
                ($urandom_range(9) < 7), rnd_a3(), $urandom, $urandom,
                ($urandom_range(9) < 7), rnd_a3(), $urandom, $urandom,
                rnd_ra(), rnd_ra());
        end

        idle(DEPTH + 4);
        chk("drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
